tt_sweep_ctrl: RTL and testbench

TT_SWEEP_CTRL -- requirements
Module: tt_sweep_ctrl

---
 rtl/tt_sweep_ctrl.sv | 145 ++++++++++++++
 tb/tb_tt_sweep_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/tt_sweep_ctrl.sv
// Purpose: sweeps all 16 {W,X,Y,Z} vectors into a 4-input function unit and counts F mismatches (optional TT_FIRST_FAIL_EN adds first-fail capture).
// Latency: each vector is driven SETTLE cycles then sampled for 1; done pulses 16*(SETTLE+1) edges after the accepting start edge.
// Backpressure: none; start is ignored unless IDLE, abort cancels a running sweep with no done pulse.
module tt_sweep_ctrl #(
    parameter logic [15:0] MINTERM_MASK = 16'hDF03,
    parameter int          SETTLE       = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       f_in,
    output logic [3:0] wxyz,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count
`ifdef TT_FIRST_FAIL_EN
    ,
    output logic [3:0] first_fail_idx,
    output logic       first_fail_valid
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

    // An out-of-range hold time would make the settle counter wrap or stall.
    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
        $error("tt_sweep_ctrl: SETTLE=%0d outside 1..15", SETTLE);
    end

    state_t     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [4:0] err_q, err_d;
    logic       pass_q, pass_d;
    logic       mismatch;
    logic [4:0] err_inc;
`ifdef TT_FIRST_FAIL_EN
    logic [3:0] ff_idx_q, ff_idx_d;
    logic       ff_vld_q, ff_vld_d;
`endif

    assign mismatch = (f_in != MINTERM_MASK[idx_q]);
    assign err_inc  = mismatch ? (err_q + 5'd1) : err_q;

    // State and datapath registers, all cleared by the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= 4'd0;
            cnt_q    <= 4'd0;
            err_q    <= 5'd0;
            pass_q   <= 1'b0;
`ifdef TT_FIRST_FAIL_EN
            ff_idx_q <= 4'd0;
            ff_vld_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            pass_q   <= pass_d;
`ifdef TT_FIRST_FAIL_EN
            ff_idx_q <= ff_idx_d;
            ff_vld_q <= ff_vld_d;
`endif
        end
    end

    // Next-state: abort beats start in IDLE and cancels DRIVE/SAMPLE; DONE always completes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start && !abort) state_d = S_DRIVE;
            S_DRIVE:  if (abort) state_d = S_IDLE;
                      else if (cnt_q == 4'd1) state_d = S_SAMPLE;
            S_SAMPLE: if (abort) state_d = S_IDLE;
                      else if (idx_q == 4'd15) state_d = S_DONE;
                      else state_d = S_DRIVE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath: index, settle counter, error count, pass and first-fail capture.
    always_comb begin
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        pass_d   = pass_q;
`ifdef TT_FIRST_FAIL_EN
        ff_idx_d = ff_idx_q;
        ff_vld_d = ff_vld_q;
`endif
        case (state_q)
            S_IDLE: if (start && !abort) begin
                idx_d    = 4'd0;
                cnt_d    = SETTLE_LD;
                err_d    = 5'd0;
                pass_d   = 1'b0;
`ifdef TT_FIRST_FAIL_EN
                ff_idx_d = 4'd0;
                ff_vld_d = 1'b0;
`endif
            end
            S_DRIVE: if (!abort && cnt_q != 4'd1) cnt_d = cnt_q - 4'd1;
            // An aborted sample is not counted; the partial count stays as it was.
            S_SAMPLE: if (!abort) begin
                err_d = err_inc;
`ifdef TT_FIRST_FAIL_EN
                if (mismatch && !ff_vld_q) begin
                    ff_idx_d = idx_q;
                    ff_vld_d = 1'b1;
                end
`endif
                // pass is settled on the last sample so it is already valid during DONE.
                if (idx_q == 4'd15) begin
                    pass_d = (err_inc == 5'd0);
                end else begin
                    idx_d = idx_q + 4'd1;
                    cnt_d = SETTLE_LD;
                end
            end
            default: ;
        endcase
    end

    // Outputs decoded from registered state; the vector is parked at 0 outside a sweep.
    always_comb begin
        busy      = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
        done      = (state_q == S_DONE);
        wxyz      = busy ? idx_q : 4'd0;
        pass      = pass_q;
        err_count = err_q;
`ifdef TT_FIRST_FAIL_EN
        first_fail_idx   = ff_idx_q;
        first_fail_valid = ff_vld_q;
`endif
    end

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
module tb_tt_sweep_ctrl;
    localparam logic [15:0] MASK = 16'hDF03;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, abort = 1'b0, f_in;
    logic [3:0] wxyz;
    logic busy, done, pass;
    logic [4:0] err_count;
    logic start3 = 1'b0, f_in3;
    logic [3:0] wxyz3;
    logic busy3, done3, pass3;
    logic [4:0] err_count3;
`ifdef TT_FIRST_FAIL_EN
    logic [3:0] ff_idx, ff_idx3;
    logic ff_vld, ff_vld3;
`endif

    int mode = 0;   // 0 ideal, 1 stuck at 0, 2 inverted at vector 13
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        case (mode)
            1:       f_in = 1'b0;
            2:       f_in = MASK[wxyz] ^ (wxyz == 4'd13);
            default: f_in = MASK[wxyz];
        endcase
        f_in3 = MASK[wxyz3];
    end

    tt_sweep_ctrl #(.MINTERM_MASK(MASK), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .f_in(f_in),
        .wxyz(wxyz), .busy(busy), .done(done), .pass(pass), .err_count(err_count)
`ifdef TT_FIRST_FAIL_EN
        , .first_fail_idx(ff_idx), .first_fail_valid(ff_vld)
`endif
    );

    tt_sweep_ctrl #(.MINTERM_MASK(MASK), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(1'b0), .f_in(f_in3),
        .wxyz(wxyz3), .busy(busy3), .done(done3), .pass(pass3), .err_count(err_count3)
`ifdef TT_FIRST_FAIL_EN
        , .first_fail_idx(ff_idx3), .first_fail_valid(ff_vld3)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One sweep on the SETTLE=1 unit; k counts edges since the accepting start edge.
    task automatic sweep(input int md, input bit restart, input int abort_k,
                         output int lat, output int ndone, output bit seq_ok,
                         output int pass_at_done);
        bit cut;
        mode = md;
        lat = -1; ndone = 0; seq_ok = 1'b1; pass_at_done = -1; cut = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (k > 0) @(negedge clk);
            if (abort_k >= 0 && k > abort_k) cut = 1'b1;
            if (!cut && k < 32 && wxyz != 4'(k / 2)) seq_ok = 1'b0;
            if (!cut && k < 32 && !busy) seq_ok = 1'b0;
            if (done) begin
                ndone++;
                if (lat < 0) begin lat = k; pass_at_done = int'(pass); end
            end
            start = restart && (k == 6 || k == 30 || done);
            abort = (k == abort_k);
        end
        start = 1'b0; abort = 1'b0;
    endtask

    typedef struct {
        int    md;
        bit    restart;
        int    exp_err;
        int    exp_pass;
        int    exp_ff;
        string name;
    } vec_t;

    vec_t tbl[4];
    int lat, ndone, pad, cyc;
    bit seq_ok;

    initial begin
        tbl[0] = '{0, 1'b0, 0, 1, -1, "ideal"};
        tbl[1] = '{1, 1'b0, 9, 0,  0, "stuck0"};
        tbl[2] = '{2, 1'b0, 1, 0, 13, "inv13"};
        tbl[3] = '{0, 1'b1, 0, 1, -1, "restart"};

        // Reset state
        #12;
        chk("rst_wxyz", int'(wxyz), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_err", int'(err_count), 0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            sweep(tbl[i].md, tbl[i].restart, -1, lat, ndone, seq_ok, pad);
            chk({tbl[i].name, "_latency"}, lat, 32);
            chk({tbl[i].name, "_ndone"}, ndone, 1);
            chk({tbl[i].name, "_wxyz_seq"}, int'(seq_ok), 1);
            chk({tbl[i].name, "_pass_at_done"}, pad, tbl[i].exp_pass);
            chk({tbl[i].name, "_err"}, int'(err_count), tbl[i].exp_err);
            chk({tbl[i].name, "_pass_held"}, int'(pass), tbl[i].exp_pass);
            chk({tbl[i].name, "_idle"}, int'(busy), 0);
`ifdef TT_FIRST_FAIL_EN
            chk({tbl[i].name, "_ff_vld"}, int'(ff_vld), (tbl[i].exp_ff >= 0) ? 1 : 0);
            if (tbl[i].exp_ff >= 0) chk({tbl[i].name, "_ff_idx"}, int'(ff_idx), tbl[i].exp_ff);
`endif
        end

        // Abort in SAMPLE of vector 5 (edge 11): errors at vectors 0,1 must be kept
        sweep(1, 1'b0, 11, lat, ndone, seq_ok, pad);
        chk("abort_ndone", ndone, 0);
        chk("abort_wxyz_seq", int'(seq_ok), 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_wxyz", int'(wxyz), 0);
        chk("abort_err_hold", int'(err_count), 2);
        chk("abort_pass", int'(pass), 0);
        sweep(0, 1'b0, -1, lat, ndone, seq_ok, pad);
        chk("post_abort_latency", lat, 32);
        chk("post_abort_err", int'(err_count), 0);
        chk("post_abort_pass", int'(pass), 1);

        // abort and start together in IDLE: abort wins
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        chk("abort_start_idle_busy", int'(busy), 0);
        chk("abort_start_idle_pass", int'(pass), 1);

        // Reset at vector 7 of a stuck-0 sweep (err=2 by then)
        mode = 1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (14) @(negedge clk);
        chk("pre_rst_wxyz", int'(wxyz), 7);
        chk("pre_rst_err", int'(err_count), 2);
        rst_n = 1'b0;
        #1;
        chk("midrst_wxyz", int'(wxyz), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_err", int'(err_count), 0);
        chk("midrst_pass", int'(pass), 0);
        chk("midrst_done", int'(done), 0);
        @(negedge clk); rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("post_rst_quiet", ndone, 0);

        // SETTLE=3: each vector held 4 cycles, done at edge +64
        @(negedge clk); start3 = 1'b1;
        @(negedge clk); start3 = 1'b0;
        seq_ok = 1'b1; lat = -1; cyc = 0;
        while (!done3 && cyc < 200) begin
            if (wxyz3 != 4'(cyc / 4)) seq_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        lat = done3 ? cyc : -1;
        chk("s3_latency", lat, 64);
        chk("s3_wxyz_seq", int'(seq_ok), 1);
        chk("s3_pass", int'(pass3), 1);
        chk("s3_err", int'(err_count3), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
